mem_port_arbiter: RTL

- Sequences a single-port, fixed-latency SRAM shared by two requesters: instruction fetch (IF) and the MEM stage, which is driven by the EX/MEM pipeline register outputs.
- Serialises accesses and generates the pipeline freeze that holds the pipeline registers while a MEM-stage load or store is outstanding.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (IF, MEM stage), the arbiter and the SRAM.
// slave  : arbiter side
// master : requester / SRAM side
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              freeze;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic              sram_we;
    logic              sram_oe;
    logic [31:0]       sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_addr, sram_wdata, sram_we, sram_oe
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_addr, sram_wdata, sram_we, sram_oe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port fixed-latency SRAM sequencer shared by instruction fetch and the
// MEM stage. Serialises accesses with alternating priority on conflict and
// produces the pipeline freeze while a MEM load/store is outstanding.
// Optional: define ARB_PERF_EN to add the stall_cnt output (freeze-cycle counter).
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_MEM} grant_t;

    state_t            state;
    grant_t            last_grant;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [31:0]       sram_wdata_q;
    logic              sram_we_q;
    logic              sram_oe_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;
    logic              if_ready_q;
    logic              mem_ready_q;
    logic              mem_req;
    logic              pick_mem;

    assign mem_req  = bus.mem_r_en | bus.mem_w_en;
    // MEM wins when alone, or on conflict when IF was served last
    assign pick_mem = mem_req & (~bus.if_req | (last_grant == GNT_IF));

    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_oe    = sram_oe_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.freeze     = mem_req & ~mem_ready_q;

    // Access sequencer: grant in IDLE, hold SRAM controls through BUSY, pulse ready in RESP.
    // The SRAM output registers double as the latched address/wdata/we of the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GNT_IF;
            cnt          <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            sram_oe_q    <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req || bus.if_req) begin
                        if (pick_mem) begin
                            sram_addr_q  <= bus.mem_addr;
                            sram_wdata_q <= bus.mem_wdata;
                            sram_we_q    <= bus.mem_w_en;
                            sram_oe_q    <= ~bus.mem_w_en;
                            last_grant   <= GNT_MEM;
                        end else begin
                            sram_addr_q  <= bus.if_addr;
                            sram_wdata_q <= '0;
                            sram_we_q    <= 1'b0;
                            sram_oe_q    <= 1'b1;
                            last_grant   <= GNT_IF;
                        end
                        cnt   <= 4'(WAIT_CYCLES - 1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (!sram_we_q) begin
                            if (last_grant == GNT_MEM) begin
                                mem_rdata_q <= bus.sram_rdata;
                            end else begin
                                if_rdata_q <= bus.sram_rdata;
                            end
                        end
                        if (last_grant == GNT_MEM) begin
                            mem_ready_q <= 1'b1;
                        end else begin
                            if_ready_q <= 1'b1;
                        end
                        sram_addr_q  <= '0;
                        sram_wdata_q <= '0;
                        sram_we_q    <= 1'b0;
                        sram_oe_q    <= 1'b0;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_PERF_EN
    // Saturating count of cycles the pipeline spends frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
